// File: rtl/sobel_window_3x3.sv
// 3x3 Sobel window on a live row plus two line-buffer rows; 4-cycle pipeline
// producing gradient magnitude (or binary edge) with de/hs/vs re-timed to match.
module sobel_window_3x3 #(
  parameter int H_ACTIVE  = 1920,
  parameter int V_ACTIVE  = 1080,
  parameter int EDGE_MODE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_de,
  input  logic       pix_hs,
  input  logic       pix_vs,
  input  logic [7:0] pix_cur,
  input  logic [7:0] line1,
  input  logic [7:0] line2,
  input  logic [7:0] thresh,
  output logic       edge_de,
  output logic       edge_hs,
  output logic       edge_vs,
  output logic [7:0] edge_data,
  output logic       edge_bin
);

  localparam logic [11:0] H_LAST = 12'(H_ACTIVE - 1);
  localparam logic [11:0] V_LAST = 12'(V_ACTIVE - 1);

  logic        vs_d;
  logic        vs_rise;
  logic [11:0] h_cnt;
  logic [11:0] v_cnt;

  assign vs_rise = pix_vs & ~vs_d;

  // A vsync rising edge wins over a same-cycle pixel increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d  <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      vs_d <= pix_vs;
      if (vs_rise) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end else if (pix_de) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        end else begin
          h_cnt <= h_cnt + 12'd1;
        end
      end
    end
  end

  // Row 0 is the oldest line (y-2), row 2 the live line; index 2 is the newest column.
  logic [2:0][7:0] w0, w1, w2;
  logic            valid_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w0        <= '0;
      w1        <= '0;
      w2        <= '0;
      valid_win <= 1'b0;
    end else if (pix_de) begin
      w0        <= {line2,   w0[2], w0[1]};
      w1        <= {line1,   w1[2], w1[1]};
      w2        <= {pix_cur, w2[2], w2[1]};
      valid_win <= (h_cnt >= 12'd2) && (v_cnt >= 12'd2);
    end
  end

  function automatic logic signed [10:0] ext(input logic [7:0] p);
    return {3'b000, p};
  endfunction

  logic signed [10:0] gx, gy;
  logic [10:0]        abs_gx, abs_gy, mag;
  logic               valid1, valid2;
  logic [7:0]         sat;
  logic               bin_c;

  assign abs_gx = gx[10] ? 11'(-gx) : 11'(gx);
  assign abs_gy = gy[10] ? 11'(-gy) : 11'(gy);
  assign sat    = (mag > 11'd255) ? 8'hFF : mag[7:0];
  assign bin_c  = valid2 && (sat > thresh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx        <= '0;
      gy        <= '0;
      valid1    <= 1'b0;
      mag       <= '0;
      valid2    <= 1'b0;
      edge_data <= '0;
      edge_bin  <= 1'b0;
    end else begin
      gx <= (ext(w0[2]) + (ext(w1[2]) <<< 1) + ext(w2[2]))
          - (ext(w0[0]) + (ext(w1[0]) <<< 1) + ext(w2[0]));
      gy <= (ext(w2[0]) + (ext(w2[1]) <<< 1) + ext(w2[2]))
          - (ext(w0[0]) + (ext(w0[1]) <<< 1) + ext(w0[2]));
      valid1    <= valid_win;
      mag       <= abs_gx + abs_gy;
      valid2    <= valid1;
      edge_bin  <= bin_c;
      edge_data <= (EDGE_MODE != 0) ? {8{bin_c}} : (valid2 ? sat : 8'h00);
    end
  end

  // Sync delay matches the four register stages of the data path.
  logic [3:0] de_sr, hs_sr, vs_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_sr <= '0;
      hs_sr <= '0;
      vs_sr <= '0;
    end else begin
      de_sr <= {de_sr[2:0], pix_de};
      hs_sr <= {hs_sr[2:0], pix_hs};
      vs_sr <= {vs_sr[2:0], pix_vs};
    end
  end

  assign edge_de = de_sr[3];
  assign edge_hs = hs_sr[3];
  assign edge_vs = vs_sr[3];

endmodule

// File: tb/tb_sobel_window_3x3.sv
// Bench for sobel_window_3x3: hand-derived vector table, randomized frames
// against an image-level Sobel model, and a mid-frame reset sequence.
`timescale 1ns/1ps
module tb_sobel_window_3x3;
  localparam int H = 8;
  localparam int V = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_de = 1'b0, pix_hs = 1'b0, pix_vs = 1'b0;
  logic [7:0] pix_cur = '0, line1 = '0, line2 = '0, thresh = '0;
  logic       edge_de0, edge_hs0, edge_vs0, edge_bin0;
  logic       edge_de1, edge_hs1, edge_vs1, edge_bin1;
  logic [7:0] edge_data0, edge_data1;

  always #5 clk = ~clk;

  sobel_window_3x3 #(.H_ACTIVE(H), .V_ACTIVE(V), .EDGE_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .pix_de(pix_de), .pix_hs(pix_hs), .pix_vs(pix_vs),
    .pix_cur(pix_cur), .line1(line1), .line2(line2), .thresh(thresh),
    .edge_de(edge_de0), .edge_hs(edge_hs0), .edge_vs(edge_vs0),
    .edge_data(edge_data0), .edge_bin(edge_bin0)
  );

  sobel_window_3x3 #(.H_ACTIVE(H), .V_ACTIVE(V), .EDGE_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .pix_de(pix_de), .pix_hs(pix_hs), .pix_vs(pix_vs),
    .pix_cur(pix_cur), .line1(line1), .line2(line2), .thresh(thresh),
    .edge_de(edge_de1), .edge_hs(edge_hs1), .edge_vs(edge_vs1),
    .edge_data(edge_data1), .edge_bin(edge_bin1)
  );

  typedef struct {
    logic       de, hs, vs;
    logic       valid;
    logic [7:0] sat;
    logic [7:0] thr;
    int         x, y;
  } rec_t;

  typedef struct {
    int         kind;
    logic [7:0] thr;
    int         px, py;
    int         exp_data;
    int         exp_bin;
  } vec_t;

  rec_t       hist[$];
  logic [7:0] img [V][H];
  int         n_vec = 0, n_err = 0;
  int         cyc = 0, first_in = -1, first_out = -1;
  int         probe_x = -1, probe_y = -1;
  int         cap_hit, cap_data0, cap_bin0, cap_data1, cap_bin1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int px(input int r, input int c);
    return int'(img[r][c]);
  endfunction

  // Sobel centred at (x-1,y-1) straight from the image, saturated to 8 bits.
  function automatic int sobel_ref(input int x, input int y);
    int gx, gy, m;
    gx = (px(y-2, x) + 2*px(y-1, x) + px(y, x))
       - (px(y-2, x-2) + 2*px(y-1, x-2) + px(y, x-2));
    gy = (px(y, x-2) + 2*px(y, x-1) + px(y, x))
       - (px(y-2, x-2) + 2*px(y-2, x-1) + px(y-2, x));
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  task automatic check_out(input rec_t e, input logic [7:0] thr_now);
    int b;
    chk("sync0", int'({edge_de0, edge_hs0, edge_vs0}), int'({e.de, e.hs, e.vs}));
    chk("sync1", int'({edge_de1, edge_hs1, edge_vs1}), int'({e.de, e.hs, e.vs}));
    if (edge_de0 && first_out < 0) first_out = cyc;
    if (e.de) begin
      b = (e.valid && (e.sat > thr_now)) ? 1 : 0;
      chk("data0", int'(edge_data0), e.valid ? int'(e.sat) : 0);
      chk("bin0", int'(edge_bin0), b);
      chk("data1", int'(edge_data1), b ? 255 : 0);
      chk("bin1", int'(edge_bin1), b);
      if (e.x == probe_x && e.y == probe_y) begin
        cap_hit   = 1;
        cap_data0 = int'(edge_data0);
        cap_bin0  = int'(edge_bin0);
        cap_data1 = int'(edge_data1);
        cap_bin1  = int'(edge_bin1);
      end
    end
  endtask

  task automatic step(input logic de, input logic hs, input logic vs,
                      input logic [7:0] cur, input logic [7:0] l1, input logic [7:0] l2,
                      input logic [7:0] thr, input int x, input int y);
    rec_t r;
    @(negedge clk);
    cyc++;
    if (hist.size() >= 4) check_out(hist[hist.size()-4], hist[hist.size()-1].thr);
    pix_de  = de;
    pix_hs  = hs;
    pix_vs  = vs;
    pix_cur = cur;
    line1   = l1;
    line2   = l2;
    thresh  = thr;
    r.de    = de;
    r.hs    = hs;
    r.vs    = vs;
    r.valid = de && (x >= 2) && (y >= 2);
    r.sat   = r.valid ? 8'(sobel_ref(x, y)) : 8'h00;
    r.thr   = thr;
    r.x     = de ? x : -1;
    r.y     = de ? y : -1;
    hist.push_back(r);
    if (hist.size() > 8) void'(hist.pop_front());
    if (de && first_in < 0) first_in = cyc;
  endtask

  task automatic idle(input logic hs, input logic vs, input logic [7:0] thr);
    step(1'b0, hs, vs, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
         8'($urandom_range(0, 255)), thr, -1, -1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_sync0"}, int'({edge_de0, edge_hs0, edge_vs0}), 0);
    chk({tag, "_sync1"}, int'({edge_de1, edge_hs1, edge_vs1}), 0);
    chk({tag, "_data0"}, int'(edge_data0), 0);
    chk({tag, "_bin0"}, int'(edge_bin0), 0);
    chk({tag, "_data1"}, int'(edge_data1), 0);
    chk({tag, "_bin1"}, int'(edge_bin1), 0);
  endtask

  task automatic apply_reset();
    rec_t z;
    @(negedge clk);
    rst_n  = 1'b0;
    pix_de = 1'b0;
    pix_hs = 1'b0;
    pix_vs = 1'b0;
    #1;
    check_zero_outputs("rst_now");
    repeat (2) @(negedge clk);
    check_zero_outputs("rst_hold");
    rst_n = 1'b1;
    z = '{de: 1'b0, hs: 1'b0, vs: 1'b0, valid: 1'b0, sat: 8'h00, thr: 8'h00, x: -1, y: -1};
    hist.delete();
    repeat (4) hist.push_back(z);
    first_in  = -1;
    first_out = -1;
  endtask

  task automatic fill_img(input int kind);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        case (kind)
          0:       img[y][x] = 8'd100;
          1:       img[y][x] = (x >= 4) ? 8'd255 : 8'd0;
          2:       img[y][x] = (y >= 3) ? 8'd50 : 8'd0;
          default: img[y][x] = 8'($urandom_range(0, 255));
        endcase
  endtask

  // rst_x/rst_y >= 0 aborts the frame with a reset just before that pixel.
  task automatic run_frame(input int rst_x, input int rst_y, input logic rand_thr,
                           input logic [7:0] thr);
    logic [7:0] t, l1, l2;
    repeat (2) idle(1'b0, 1'b1, thr);
    repeat ($urandom_range(1, 3)) idle(1'b0, 1'b0, thr);
    for (int y = 0; y < V; y++) begin
      idle(1'b1, 1'b0, thr);
      repeat ($urandom_range(1, 3)) idle(1'b0, 1'b0, thr);
      for (int x = 0; x < H; x++) begin
        if (x == rst_x && y == rst_y) begin
          apply_reset();
          return;
        end
        t  = rand_thr ? 8'($urandom_range(0, 255)) : thr;
        l1 = (y >= 1) ? img[y-1][x] : 8'($urandom_range(0, 255));
        l2 = (y >= 2) ? img[y-2][x] : 8'($urandom_range(0, 255));
        step(1'b1, 1'b0, 1'b0, img[y][x], l1, l2, t, x, y);
      end
      repeat ($urandom_range(1, 3)) idle(1'b0, 1'b0, thr);
    end
    repeat (5) idle(1'b0, 1'b0, thr);
  endtask

  task automatic run_probe(input string tag, input int kind, input logic [7:0] thr,
                           input int x, input int y, input int exp_data, input int exp_bin);
    fill_img(kind);
    probe_x = x;
    probe_y = y;
    cap_hit = 0;
    run_frame(-1, -1, 1'b0, thr);
    chk({tag, "_hit"}, cap_hit, 1);
    chk({tag, "_data0"}, cap_data0, exp_data);
    chk({tag, "_bin0"}, cap_bin0, exp_bin);
    chk({tag, "_data1"}, cap_data1, exp_bin ? 255 : 0);
    chk({tag, "_bin1"}, cap_bin1, exp_bin);
    probe_x = -1;
    probe_y = -1;
  endtask

  initial begin
    vec_t tbl[10];
    // kind: 0 flat 100, 1 vertical step at column 4, 2 horizontal step at row 3
    tbl[0] = '{kind: 0, thr: 8'd0,   px: 4, py: 3, exp_data: 0,   exp_bin: 0};
    tbl[1] = '{kind: 1, thr: 8'd128, px: 4, py: 2, exp_data: 255, exp_bin: 1};
    tbl[2] = '{kind: 1, thr: 8'd128, px: 5, py: 5, exp_data: 255, exp_bin: 1};
    tbl[3] = '{kind: 1, thr: 8'd128, px: 6, py: 3, exp_data: 0,   exp_bin: 0};
    tbl[4] = '{kind: 1, thr: 8'd128, px: 4, py: 1, exp_data: 0,   exp_bin: 0};
    tbl[5] = '{kind: 1, thr: 8'd128, px: 3, py: 4, exp_data: 0,   exp_bin: 0};
    tbl[6] = '{kind: 2, thr: 8'd200, px: 3, py: 3, exp_data: 200, exp_bin: 0};
    tbl[7] = '{kind: 2, thr: 8'd199, px: 5, py: 4, exp_data: 200, exp_bin: 1};
    tbl[8] = '{kind: 2, thr: 8'd199, px: 5, py: 5, exp_data: 0,   exp_bin: 0};
    tbl[9] = '{kind: 2, thr: 8'd199, px: 1, py: 4, exp_data: 0,   exp_bin: 0};

    apply_reset();

    for (int i = 0; i < 10; i++) begin
      run_probe($sformatf("tbl%0d", i), tbl[i].kind, tbl[i].thr, tbl[i].px, tbl[i].py,
                tbl[i].exp_data, tbl[i].exp_bin);
      if (i == 0) chk("first_de_latency", first_out - first_in, 4);
    end

    for (int f = 0; f < 4; f++) begin
      fill_img(3);
      run_frame(-1, -1, f[0], 8'($urandom_range(0, 255)));
    end

    fill_img(0);
    run_frame(3, 3, 1'b0, 8'd100);
    repeat (3) idle(1'b0, 1'b0, 8'd100);
    check_zero_outputs("post_rst_idle");
    run_probe("post_rst", 0, 8'd50, 4, 4, 0, 0);
    chk("post_rst_latency", first_out - first_in, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
